rd_lane_encoder: RTL
====================

# rd_lane_encoder

Parametrised running-disparity (RD) selector for the TX PCS, placed after the 8b/10b code lookup and before the PMA serializer. It accepts SYMS symbols per clock, each offered as an RD− and an RD+ 10-bit codeword. For each symbol it picks the correct codeword and updates RD from the actual disparity of the codeword chosen, so RD does not simply toggle. It also adds a registered output, an RD preload, an illegal-disparity flag and a saturating error counter.

## Interface
Parameters:
- SYMS, 2, symbols per word; legal range 1..4.
- RD_INIT, 0, reset value of RD (0 = negative, 1 = positive).
- CNT_W, 8, width of the error counter.

Ports:
- Bit_Rate_10  in  1  word clock; all state updates on its rising edge.
- Rst  in  1  reset, asynchronous, active-low.
- enable  in  1  word valid; when low, all state holds.
- data_neg  in  10*SYMS  RD− codewords; symbol i is bits [10i+9:10i], and symbol 0 is transmitted first.
- data_pos  in  10*SYMS  RD+ codewords, same packing as data_neg.
- TXDataK  in  SYMS  control-symbol flags; registered alongside the data and passed through to TXDataK_out.
- rd_load  in  1  preload request for RD.
- rd_load_val  in  1  value to preload into RD.
- Data_10  out  10*SYMS  selected codewords, registered.
- TXDataK_out  out  SYMS  registered copy of TXDataK.
- enable_PMA  out  1  registered valid for Data_10.
- rd_state  out  1  current RD register (the RD that applies to the next word).
- disp_err  out  1  registered flag: at least one symbol in the last accepted word had an illegal disparity.
- err_cnt  out  CNT_W  count of words that raised disp_err; saturates.

## Operation
- Start RD for the word:
  - rd_in = rd_load_val when rd_load = 1;
  - otherwise rd_in = rd_state.
- Per-symbol chain, i = 0..SYMS−1, evaluated combinationally within one cycle:
  - Select: sel_i = data_pos[i] if r_i = 1, else data_neg[i]. r_0 = rd_in.
  - Count: ones_i = popcount(sel_i), 0..10, held in 4 bits.
  - ones_i = 6 → r_{i+1} = 1.
  - ones_i = 4 → r_{i+1} = 0.
  - ones_i = 5 → r_{i+1} = r_i.
  - Any other count → r_{i+1} = r_i, and bad_i = 1.
- When enable = 1, at the clock edge:
  - Data_10 ← {sel_{SYMS−1}, …, sel_0};
  - TXDataK_out ← TXDataK;
  - enable_PMA ← 1;
  - rd_state ← r_SYMS;
  - disp_err ← OR of all bad_i;
  - if any bad_i is set and err_cnt < 2^CNT_W − 1, then err_cnt ← err_cnt + 1.
- When enable = 0, at the clock edge:
  - enable_PMA ← 0 and disp_err ← 0;
  - Data_10, TXDataK_out and err_cnt hold;
  - rd_state ← rd_load_val if rd_load = 1, otherwise it holds.
- rd_load together with enable = 1: the loaded value is used as the start RD of that same word.
- No sticky state beyond err_cnt, which clears only on reset.

## Timing
- Latency: 1 cycle from inputs to Data_10, enable_PMA and disp_err.
- Throughput: one word per cycle; no backpressure.
- Reset (Rst = 0), asynchronous and taking effect immediately:
  - Data_10 = 0, TXDataK_out = 0, enable_PMA = 0, disp_err = 0, err_cnt = 0, rd_state = RD_INIT.
- Reset asserted mid-stream: the word in flight is dropped.
- After reset deassertion, the first rising edge with enable = 1 produces the first valid word.
- rd_state is a register and is visible one cycle after the word that produced it.
- Critical path: SYMS chained popcount/mux stages. SYMS > 4 is not supported.

## Test plan
- Reset, RD_INIT = 0, SYMS = 2: hold Rst = 0 → all outputs 0 and rd_state = 0. Release Rst, keep enable = 0 for 3 cycles → enable_PMA stays 0.
- K28.5 alternation: every word, for both symbols, data_neg = 0x0FA and data_pos = 0x305, with enable = 1.
  - Every word → Data_10 = {0x305, 0x0FA}, rd_state = 0, enable_PMA = 1, disp_err = 0.
- Balanced code preserves RD: symbol 0 = K28.5 (0x0FA / 0x305), symbol 1 = D21.5 (0x2AA in both fields), start RD = 0.
  - Data_10 = {0x2AA, 0x0FA}, rd_state = 1.
  - Next word, same inputs → Data_10 = {0x2AA, 0x305}, rd_state = 0.
- Preload: from rd_state = 0, drive rd_load = 1, rd_load_val = 1 and enable = 1 with K28.5 on both symbols.
  - Data_10 = {0x0FA, 0x305}, rd_state = 1.
  - rd_load with enable = 0 → rd_state = 1 next cycle and Data_10 unchanged.
- Illegal disparity: symbol 0 = 0x3FF in both fields, symbol 1 = D21.5, rd_state = 1.
  - disp_err = 1, err_cnt increments by 1, rd_state stays 1.
  - With CNT_W = 2, drive 5 bad words → err_cnt = 3 and holds.
- Enable gap mid-stream: toggle enable 1,0,0,1 during the K28.5 stream.
  - RD sequence continues unbroken across the gap.
  - enable_PMA reads 1,0,0,1, and Data_10 holds its value during the gap.

Source files
------------

// File: rtl/rd_lane_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : rd_lane_encoder_if
//  Description : Word-side bundle of the RD lane encoder: codeword pairs in,
//                selected codewords, RD state and error status out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rd_lane_encoder_if #(
    parameter int SYMS  = 2,
    parameter int CNT_W = 8
);
    logic                  enable;
    logic [10*SYMS-1:0]    data_neg;
    logic [10*SYMS-1:0]    data_pos;
    logic [SYMS-1:0]       TXDataK;
    logic                  rd_load;
    logic                  rd_load_val;
    logic [10*SYMS-1:0]    Data_10;
    logic [SYMS-1:0]       TXDataK_out;
    logic                  enable_PMA;
    logic                  rd_state;
    logic                  disp_err;
    logic [CNT_W-1:0]      err_cnt;

    modport master (
        output enable, data_neg, data_pos, TXDataK, rd_load, rd_load_val,
        input  Data_10, TXDataK_out, enable_PMA, rd_state, disp_err, err_cnt
    );

    modport slave (
        input  enable, data_neg, data_pos, TXDataK, rd_load, rd_load_val,
        output Data_10, TXDataK_out, enable_PMA, rd_state, disp_err, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/rd_lane_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : rd_lane_encoder
//  Description : Running-disparity selector between the 8b/10b lookup and the
//                serializer; picks RD-/RD+ codewords per symbol and tracks RD.
//  Revision    : 1.0 - initial release
// ============================================================================
module rd_lane_encoder #(
    parameter int SYMS    = 2,
    parameter bit RD_INIT = 1'b0,
    parameter int CNT_W   = 8
) (
    input  logic               Bit_Rate_10,
    input  logic               Rst,
    rd_lane_encoder_if.slave   bus
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    function automatic logic [3:0] popcount10(input logic [9:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int b = 0; b < 10; b++) begin
            n = n + {3'b000, v[b]};
        end
        return n;
    endfunction

    logic [10*SYMS-1:0] w_sel;
    logic [9:0]         w_cw;
    logic [3:0]         w_ones;
    logic               w_rd_chain;
    logic               w_rd_out;
    logic               w_bad_any;

    logic [10*SYMS-1:0] r_data;
    logic [SYMS-1:0]    r_txk;
    logic               r_pma;
    logic               r_rd;
    logic               r_derr;
    logic [CNT_W-1:0]   r_err_cnt;

    // RD ripples symbol to symbol; symbol 0 leaves the lane first.
    always_comb begin
        w_sel      = '0;
        w_cw       = '0;
        w_ones     = '0;
        w_bad_any  = 1'b0;
        w_rd_chain = bus.rd_load ? bus.rd_load_val : r_rd;
        for (int i = 0; i < SYMS; i++) begin
            w_cw  = w_rd_chain ? bus.data_pos[10*i +: 10] : bus.data_neg[10*i +: 10];
            w_sel[10*i +: 10] = w_cw;
            w_ones = popcount10(w_cw);
            case (w_ones)
                4'd6:    w_rd_chain = 1'b1;
                4'd4:    w_rd_chain = 1'b0;
                4'd5:    w_rd_chain = w_rd_chain;
                default: w_bad_any  = 1'b1;
            endcase
        end
        w_rd_out = w_rd_chain;
    end

    always_ff @(posedge Bit_Rate_10 or negedge Rst) begin
        if (!Rst) begin
            r_data    <= '0;
            r_txk     <= '0;
            r_pma     <= 1'b0;
            r_rd      <= RD_INIT;
            r_derr    <= 1'b0;
            r_err_cnt <= '0;
        end else if (bus.enable) begin
            r_data <= w_sel;
            r_txk  <= bus.TXDataK;
            r_pma  <= 1'b1;
            r_rd   <= w_rd_out;
            r_derr <= w_bad_any;
            if (w_bad_any && (r_err_cnt != c_CNT_MAX)) begin
                r_err_cnt <= r_err_cnt + c_CNT_ONE;
            end
        end else begin
            r_pma  <= 1'b0;
            r_derr <= 1'b0;
            if (bus.rd_load) begin
                r_rd <= bus.rd_load_val;
            end
        end
    end

    assign bus.Data_10     = r_data;
    assign bus.TXDataK_out = r_txk;
    assign bus.enable_PMA  = r_pma;
    assign bus.rd_state    = r_rd;
    assign bus.disp_err    = r_derr;
    assign bus.err_cnt     = r_err_cnt;

endmodule
`default_nettype wire
